// File: rtl/clarvi_loader_pkg.sv
// Shared types and constants for the boot-time UART-to-RAM loader.
// S_CHK exists only when CLARVI_LOADER_CHECKSUM_EN is defined.
package clarvi_loader_pkg;

  localparam logic [7:0] MAGIC_DEFAULT = 8'hA5;
  localparam int         HDR_BYTES     = 4;
  localparam int         WORD_BYTES    = 4;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR_LO,
    S_ADDR_HI,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_WRITE,
`ifdef CLARVI_LOADER_CHECKSUM_EN
    S_CHK,
`endif
    S_FIN
  } loader_state_t;

endpackage

// File: rtl/clarvi_loader_word_asm.sv
// Little-endian word assembler: shifts accepted bytes in, flags the last byte of a word.
// Zero latency: o_word/o_word_vld are valid in the same cycle as the final byte; no backpressure of its own.
module clarvi_loader_word_asm
  import clarvi_loader_pkg::*;
(
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_vld,
  input  logic [7:0]              i_dat,
  output logic [8*WORD_BYTES-1:0] o_word,
  output logic                    o_word_vld
);

  localparam int CNT_W = $clog2(WORD_BYTES);
  localparam int SH_W  = 8 * (WORD_BYTES - 1);

  logic [CNT_W-1:0] r_cnt;
  logic [SH_W-1:0]  r_shift;

  // Earlier bytes sit in the low lanes, so the newest byte lands on top.
  assign o_word     = {i_dat, r_shift};
  assign o_word_vld = i_vld && (r_cnt == CNT_W'(WORD_BYTES - 1));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt   <= '0;
      r_shift <= '0;
    end else if (i_vld) begin
      r_cnt   <= r_cnt + CNT_W'(1);
      r_shift <= {i_dat, r_shift[SH_W-1:8]};
    end
  end

endmodule

// File: rtl/clarvi_mem_loader.sv
// Framed UART byte stream -> single-cycle Avalon-MM word writes; peak 1 word / 5 cycles, rx_ready low in WRITE/FIN.
// Optional trailing 8-bit checksum byte enabled by CLARVI_LOADER_CHECKSUM_EN.
module clarvi_mem_loader
  import clarvi_loader_pkg::*;
#(
  parameter int         ADDR_W = 14,
  parameter logic [7:0] MAGIC  = MAGIC_DEFAULT
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_valid,
  output logic              o_rx_ready,
  output logic [ADDR_W-1:0] o_address,
  output logic [3:0]        o_byteenable,
  output logic              o_chipselect,
  output logic              o_write,
  output logic [31:0]       o_writedata,
  output logic              o_busy,
  output logic              o_cpu_hold,
  output logic              o_done,
  output logic              o_error
);

  loader_state_t     r_state;
  logic              r_rx_ready;
  logic [ADDR_W-1:0] r_ptr;
  logic [7:0]        r_lo;
  logic [15:0]       r_remaining;
  logic              r_wr;
  logic [31:0]       r_writedata;
  logic              r_busy;
  logic              r_done;
  logic              r_error;

  logic        w_xfer;
  logic [15:0] w_hdr_word;
  logic [31:0] w_word;
  logic        w_word_vld;

  assign w_xfer     = i_rx_valid && r_rx_ready;
  assign w_hdr_word = {i_rx_data, r_lo};

  clarvi_loader_word_asm u_word_asm (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_vld      (w_xfer && (r_state == S_DATA)),
    .i_dat      (i_rx_data),
    .o_word     (w_word),
    .o_word_vld (w_word_vld)
  );

`ifdef CLARVI_LOADER_CHECKSUM_EN
  logic [7:0] r_sum;

  // Running sum of everything after MAGIC; restarts whenever the FSM idles.
  always_ff @(posedge i_clk) begin
    if (i_reset || (r_state == S_IDLE)) begin
      r_sum <= '0;
    end else if (w_xfer) begin
      r_sum <= r_sum + i_rx_data;
    end
  end
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_rx_ready  <= 1'b0;
      r_ptr       <= '0;
      r_lo        <= '0;
      r_remaining <= '0;
      r_wr        <= 1'b0;
      r_writedata <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_wr   <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_rx_ready <= 1'b1;
          if (w_xfer && (i_rx_data == MAGIC)) begin
            r_state <= S_ADDR_LO;
            r_busy  <= 1'b1;
            r_error <= 1'b0;
          end
        end
        S_ADDR_LO: if (w_xfer) begin
          r_lo    <= i_rx_data;
          r_state <= S_ADDR_HI;
        end
        S_ADDR_HI: if (w_xfer) begin
          if (w_hdr_word[15:ADDR_W] != '0) begin
            r_error <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_ptr   <= w_hdr_word[ADDR_W-1:0];
            r_state <= S_LEN_LO;
          end
        end
        S_LEN_LO: if (w_xfer) begin
          r_lo    <= i_rx_data;
          r_state <= S_LEN_HI;
        end
        S_LEN_HI: if (w_xfer) begin
          r_remaining <= w_hdr_word;
          if (w_hdr_word == 16'd0) begin
`ifdef CLARVI_LOADER_CHECKSUM_EN
            r_state <= S_CHK;
`else
            r_state    <= S_FIN;
            r_rx_ready <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
`endif
          end else begin
            r_state <= S_DATA;
          end
        end
        S_DATA: if (w_word_vld) begin
          r_writedata <= w_word;
          r_wr        <= 1'b1;
          r_rx_ready  <= 1'b0;
          r_state     <= S_WRITE;
        end
        S_WRITE: begin
          r_ptr       <= r_ptr + ADDR_W'(1);
          r_remaining <= r_remaining - 16'd1;
          if (r_remaining == 16'd1) begin
`ifdef CLARVI_LOADER_CHECKSUM_EN
            r_state    <= S_CHK;
            r_rx_ready <= 1'b1;
`else
            r_state <= S_FIN;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
`endif
          end else begin
            r_state    <= S_DATA;
            r_rx_ready <= 1'b1;
          end
        end
`ifdef CLARVI_LOADER_CHECKSUM_EN
        S_CHK: if (w_xfer) begin
          r_busy <= 1'b0;
          if (8'(r_sum + i_rx_data) == 8'h00) begin
            r_state    <= S_FIN;
            r_rx_ready <= 1'b0;
            r_done     <= 1'b1;
          end else begin
            r_error <= 1'b1;
            r_state <= S_IDLE;
          end
        end
`endif
        S_FIN: begin
          r_state    <= S_IDLE;
          r_rx_ready <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_rx_ready   = r_rx_ready;
  assign o_address    = r_ptr;
  assign o_byteenable = 4'hF;
  assign o_chipselect = r_wr;
  assign o_write      = r_wr;
  assign o_writedata  = r_writedata;
  assign o_busy       = r_busy;
  assign o_cpu_hold   = r_busy;
  assign o_done       = r_done;
  assign o_error      = r_error;

endmodule

// File: tb/tb_clarvi_mem_loader.sv
// Directed frames against a frame-level model of expected RAM writes, done pulses and error state.
module tb_clarvi_mem_loader;
  import clarvi_loader_pkg::*;

  localparam int AW = 14;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic          rx_ready;
  logic [AW-1:0] address;
  logic [3:0]    byteenable;
  logic          chipselect, write_s, busy, cpu_hold, done, error;
  logic [31:0]   writedata;

  clarvi_mem_loader #(.ADDR_W(AW), .MAGIC(8'hA5)) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_rx_data    (rx_data),
    .i_rx_valid   (rx_valid),
    .o_rx_ready   (rx_ready),
    .o_address    (address),
    .o_byteenable (byteenable),
    .o_chipselect (chipselect),
    .o_write      (write_s),
    .o_writedata  (writedata),
    .o_busy       (busy),
    .o_cpu_hold   (cpu_hold),
    .o_done       (done),
    .o_error      (error)
  );

  always #5 clk = ~clk;

  typedef logic [7:0] bq_t[$];
  typedef struct packed {
    logic [AW-1:0] a;
    logic [31:0]   d;
  } wr_t;

  int          n_chk = 0;
  int          n_fail = 0;
  int          n_writes = 0;
  int          n_done = 0;
  bit          prev_wr = 1'b0;
  wr_t         exp_q[$];
  wr_t         cmp_e;
  logic [31:0] mem [0:(1<<AW)-1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Per-cycle monitor: every write strobe must match the next write the model predicted.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_wr = 1'b0;
      end else begin
        chk("byteenable", 32'(byteenable), 32'hF);
        chk("cpu_hold_eq_busy", 32'(cpu_hold), 32'(busy));
        chk("chipselect_eq_write", 32'(chipselect), 32'(write_s));
        if (write_s) begin
          chk("rx_ready_in_write", 32'(rx_ready), 32'd0);
          chk("write_single_cycle", 32'(prev_wr), 32'd0);
          if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_write: got write @0x%0h data 0x%0h, required none", address, writedata);
          end else begin
            cmp_e = exp_q.pop_front();
            chk("write_addr", 32'(address), 32'(cmp_e.a));
            chk("write_data", writedata, cmp_e.d);
          end
          mem[address] = writedata;
          n_writes++;
        end
        if (done) n_done++;
        prev_wr = write_s;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    rx_valid = 1'b0;
    repeat (gap) tick();
    rx_data  = b;
    rx_valid = 1'b1;
    t = 0;
    while (!rx_ready && t < 200) begin
      tick();
      t++;
    end
    if (t >= 200) begin
      n_chk++;
      n_fail++;
      $display("FAIL rx_ready_timeout: got rx_ready=0 for 200 cycles, required 1");
    end
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic check_reset_vals();
    chk("rst_rx_ready", 32'(rx_ready), 32'd0);
    chk("rst_write", 32'(write_s), 32'd0);
    chk("rst_chipselect", 32'(chipselect), 32'd0);
    chk("rst_address", 32'(address), 32'd0);
    chk("rst_writedata", writedata, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_byteenable", 32'(byteenable), 32'hF);
  endtask

  // Frame-level model: predicts writes/done/error from the frame's contents, then drives it.
  task automatic send_frame(input logic [15:0] addr, input bq_t dat, input int gap_max, input bit bad_sum);
    bq_t           hdr;
    logic [15:0]   len;
    logic [7:0]    sum;
    logic [AW-1:0] a;
    wr_t           w;
    int            w0, d0, nwords, n_hdr;
    bit            bad_addr, exp_err, exp_done;
    len      = 16'(dat.size() / 4);
    hdr      = {addr[7:0], addr[15:8], len[7:0], len[15:8]};
    bad_addr = (addr >> AW) != 0;
    w0 = n_writes;
    d0 = n_done;
    sum = 8'h00;
    foreach (hdr[i]) sum = sum + hdr[i];
    foreach (dat[i]) sum = sum + dat[i];
    if (bad_addr) begin
      nwords = 0; exp_err = 1'b1; exp_done = 1'b0;
    end else begin
      nwords = int'(len);
      a = addr[AW-1:0];
      for (int k = 0; k < nwords; k++) begin
        w.a = a;
        w.d = {dat[4*k+3], dat[4*k+2], dat[4*k+1], dat[4*k]};
        exp_q.push_back(w);
        a = a + AW'(1);
      end
`ifdef CLARVI_LOADER_CHECKSUM_EN
      exp_err = bad_sum; exp_done = !bad_sum;
`else
      exp_err = 1'b0; exp_done = 1'b1;
`endif
    end
    send_byte(8'hA5, $urandom_range(0, gap_max));
    chk("busy_after_magic", 32'(busy), 32'd1);
    n_hdr = bad_addr ? 2 : HDR_BYTES;
    for (int i = 0; i < n_hdr; i++) send_byte(hdr[i], $urandom_range(0, gap_max));
    if (!bad_addr) begin
      foreach (dat[i]) begin
        send_byte(dat[i], $urandom_range(0, gap_max));
        if ((i % 4) != 3) chk("no_early_write", 32'(n_writes - w0), 32'(i / 4));
      end
`ifdef CLARVI_LOADER_CHECKSUM_EN
      send_byte(bad_sum ? 8'(8'h01 - sum) : 8'(8'h00 - sum), $urandom_range(0, gap_max));
`endif
    end
    repeat (4) tick();
    chk("frame_writes", 32'(n_writes - w0), 32'(nwords));
    chk("frame_done_pulses", 32'(n_done - d0), 32'(exp_done));
    chk("frame_error", 32'(error), 32'(exp_err));
    chk("frame_busy_low", 32'(busy), 32'd0);
    chk("frame_pending_writes", 32'(exp_q.size()), 32'd0);
    unused_bad_sum(bad_sum);
  endtask

  task automatic unused_bad_sum(input bit b);
    if (b === 1'bx) $display("note: bad_sum unknown");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t d;
    rst = 1'b1;
    repeat (3) tick();
    check_reset_vals();
    rst = 1'b0;
    tick();
    chk("rx_ready_after_reset", 32'(rx_ready), 32'd1);

    // Garbage in IDLE is dropped.
    send_byte(8'h00, 0);
    send_byte(8'h5A, 2);
    chk("idle_discard_busy", 32'(busy), 32'd0);

    d = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    send_frame(16'h0010, d, 0, 1'b0);
    chk("lit_frameA_w0", mem[16'h0010], 32'h44332211);
    chk("lit_frameA_w1", mem[16'h0011], 32'h88776655);

    d = {8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h01, 8'h02, 8'h03, 8'h04};
    send_frame(16'h3FFF, d, 0, 1'b0);
    chk("lit_wrap_top", mem[16'h3FFF], 32'hDEADBEEF);
    chk("lit_wrap_zero", mem[0], 32'h04030201);

    d = {8'h99, 8'h99, 8'h99, 8'h99};
    send_frame(16'h4000, d, 0, 1'b0);
    d = {8'hBE, 8'hBA, 8'hFE, 8'hCA};
    send_frame(16'h0020, d, 0, 1'b0);
    chk("lit_recover", mem[16'h0020], 32'hCAFEBABE);

    d = {};
    send_frame(16'h0005, d, 0, 1'b0);

    d = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    send_frame(16'h0030, d, 10, 1'b0);
    chk("lit_gapped_w0", mem[16'h0030], 32'h44332211);
    chk("lit_gapped_w1", mem[16'h0031], 32'h88776655);

    d = {8'hA5, 8'hA5, 8'hA5, 8'hA5};
    send_frame(16'h0040, d, 1, 1'b0);
    chk("lit_magic_as_data", mem[16'h0040], 32'hA5A5A5A5);

    // Reset two bytes into the first data word: nothing may be written.
    begin
      int w0;
      w0 = n_writes;
      send_byte(8'hA5, 0);
      send_byte(8'h00, 0);
      send_byte(8'h01, 0);
      send_byte(8'h02, 0);
      send_byte(8'h00, 0);
      send_byte(8'h11, 0);
      send_byte(8'h22, 0);
      rst = 1'b1;
      tick();
      check_reset_vals();
      tick();
      rst = 1'b0;
      tick();
      chk("rx_ready_after_midreset", 32'(rx_ready), 32'd1);
      chk("midreset_no_write", 32'(n_writes - w0), 32'd0);
    end
    d = {8'h11, 8'h22, 8'h33, 8'h44};
    send_frame(16'h0100, d, 0, 1'b0);
    chk("lit_after_reset", mem[16'h0100], 32'h44332211);

`ifdef CLARVI_LOADER_CHECKSUM_EN
    d = {8'h10, 8'h20, 8'h30, 8'h40};
    send_frame(16'h0050, d, 0, 1'b1);
    send_frame(16'h0051, d, 0, 1'b0);
    chk("lit_chk_good", mem[16'h0051], 32'h40302010);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/clarvi_mem_loader.md
Name: clarvi_mem_loader

Overview:
- Boot-time loader upstream of the dual-port on-chip RAM's second Avalon slave (s2).
- Consumes a framed byte stream from the UART receiver, assembles little-endian 32-bit words, and issues single-cycle Avalon-MM writes into the RAM.
- Holds the CPU off (cpu_hold) while a frame is in progress.

Parameters:
- ADDR_W, 14, word-address width of the RAM port (16384 words)
- MAGIC, 8'hA5, frame start byte

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- rx_data  in  8  received byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  loader accepts byte; transfer occurs when rx_valid & rx_ready on a rising clk edge
- address  out  ADDR_W  word address to RAM s2
- byteenable  out  4  byte lanes; constant 4'hF
- chipselect  out  1  asserted only on the write cycle
- write  out  1  asserted only on the write cycle
- writedata  out  32  assembled word
- busy  out  1  frame in progress
- cpu_hold  out  1  equals busy
- done  out  1  one-cycle pulse on successful frame end
- error  out  1  sticky; cleared by reset or the next accepted MAGIC

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset values: all outputs 0 except byteenable = 4'hF. State = IDLE. rx_ready goes to 1 on the first cycle after reset deasserts.
- Frame format: MAGIC, ADDR_LO, ADDR_HI, LEN_LO, LEN_HI, then LEN words of 4 bytes each (byte 0 = writedata[7:0]).
- States: IDLE, ADDR_LO, ADDR_HI, LEN_LO, LEN_HI, DATA, WRITE, (CHK), FIN.
- IDLE:
  - rx_ready = 1.
  - Non-MAGIC bytes are discarded.
  - A MAGIC byte goes to ADDR_LO, sets busy and clears error.
- ADDR/LEN states:
  - Each consumes one byte into a 16-bit register.
  - At the end of ADDR_HI, if addr[15:ADDR_W] != 0: set error, clear busy, go to IDLE (abort).
  - At the end of LEN_HI, LEN == 0 goes directly to CHK or FIN with no writes.
- DATA:
  - A 2-bit byte counter shifts bytes into writedata.
  - The 4th byte accepted goes to WRITE.
- WRITE:
  - Lasts exactly one cycle.
  - chipselect = write = 1, address = current pointer, rx_ready = 0.
  - The RAM has no waitrequest, so the write completes in this cycle.
  - Then the pointer increments modulo 2^ADDR_W (16383 wraps to 0 silently) and the remaining count decrements.
  - If remaining > 0, go to DATA; otherwise go to CHK or FIN.
- FIN: one cycle; done = 1, busy drops to 0, then IDLE. rx_ready = 0 in FIN.
- Throughput: rx_ready = 1 in all byte-consuming states. Peak rate is 1 word per 5 cycles.
- rx_valid low stalls any byte state indefinitely; there is no timeout.
- Reset mid-frame: aborts immediately to IDLE. No write strobe may appear in the cycle after reset asserts. Words already written remain in the RAM.
- A MAGIC byte received mid-frame is treated as data, not as a resync.

Optional Feature:
- Macro: CLARVI_LOADER_CHECKSUM_EN.
- Enabled:
  - An 8-bit running sum (mod 256) covers every byte after MAGIC, including the header.
  - State CHK follows the last word (or LEN_HI when LEN = 0) and consumes one byte.
  - If sum + byte == 8'h00, go to FIN with done.
  - Otherwise set error, clear busy, go to IDLE with no done pulse. Writes already issued are not undone.
- Disabled: no CHK state and no sum register; the frame ends after the last word.

Decomposition:
- Package clarvi_loader_pkg: state enum loader_state_t, MAGIC_DEFAULT, HDR_BYTES = 4, WORD_BYTES = 4.
- One natural sub-module: clarvi_loader_word_asm (byte counter plus shift register; outputs word and word_valid). It is reused by the FSM.

Test Plan:
- Frame A5 10 00 02 00 + 8 bytes 11 22 33 44 55 66 77 88 -> writes 0x44332211 @0x0010 and 0x88776655 @0x0011; each write strobe lasts 1 cycle; done pulses once; busy low afterwards.
- Header address 0x3FFF, LEN = 2 -> writes @0x3FFF then @0x0000; error = 0.
- Header ADDR_HI = 0x40 -> error = 1, no write strobes, state returns to IDLE; a following valid frame clears error and loads.
- LEN = 0 -> zero writes; done pulses.
- rx_valid gapped randomly 0-10 cycles within a word -> same RAM contents as back-to-back input; no write until the 4th byte.
- Reset asserted after 2 data bytes -> no write; outputs at reset values. With CLARVI_LOADER_CHECKSUM_EN, a wrong checksum byte -> error = 1 and no done pulse; the correct byte -> done.
